mem_arbiter: RTL

//  Two-to-one arbiter between the instruction and data caches and the single main-memory port.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_owner_fifo.sv | 54 +++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state, requester ids and sizing helpers for the memory arbiter.
// MEM_DATA_BITS sets the beat width (128 when not given on the command line).
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// Owner-id FIFO: one bit per outstanding read, popped in memory response order.
// Push while full is accepted only together with a pop.
module mem_arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = ceil_log2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  logic        i_push_id,
  input  logic        i_pop,
  output logic        o_head,
  output logic [PW:0] o_count,
  output logic        o_empty
);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = r_count == (PW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_push_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one icache/dcache arbiter onto one memory port with in-order read routing.
// MEM_ARB_DCACHE_PRIO_EN: dcache wins every tie instead of round-robin.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS       = 28,
  parameter int DATA_BITS       = `MEM_DATA_BITS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_data_valid,
  output logic                   ic_data_ready,
  input  logic [DATA_BITS-1:0]   ic_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_data_mask,
  output logic                   ic_resp_valid,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_data_valid,
  output logic                   dc_data_ready,
  input  logic [DATA_BITS-1:0]   dc_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_data_mask,
  output logic                   dc_resp_valid,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   err_orphan_resp
);

  localparam int PW = ceil_log2(MAX_OUTSTANDING);
  localparam logic [PW:0] MAX_CNT = (PW+1)'(MAX_OUTSTANDING);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_owner;
  logic       r_rr_last;
  logic       r_addr_done;
  logic       r_data_done;
  logic       r_err;

  logic                   w_head;
  logic                   w_empty;
  logic [PW:0]            w_count;
  logic                   w_room;
  logic                   w_ic_elig;
  logic                   w_dc_elig;
  logic                   w_any;
  logic                   w_win;
  logic                   w_act;
  logic                   w_sel;
  logic                   w_s_valid;
  logic                   w_s_rw;
  logic                   w_s_dvalid;
  logic [ADDR_BITS-1:0]   w_s_addr;
  logic [DATA_BITS-1:0]   w_s_bits;
  logic [DATA_BITS/8-1:0] w_s_mask;
  logic                   w_addr_hs;
  logic                   w_data_hs;
  logic                   w_done;
  logic                   w_push;

  // Occupancy is the registered count, so a same-cycle pop frees nothing.
  assign w_room    = w_count < MAX_CNT;
  assign w_ic_elig = ic_req_valid && (ic_req_rw || w_room);
  assign w_dc_elig = dc_req_valid && (dc_req_rw || w_room);
  assign w_any     = w_ic_elig || w_dc_elig;

`ifdef MEM_ARB_DCACHE_PRIO_EN
  assign w_win = w_dc_elig;
`else
  assign w_win = (w_ic_elig && w_dc_elig) ? ~r_rr_last : w_dc_elig;
`endif

  assign w_act = (r_state == ARB_LOCK) || w_any;
  assign w_sel = (r_state == ARB_LOCK) ? r_owner : w_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_owner     <= REQ_IC;
      r_rr_last   <= REQ_DC;
      r_addr_done <= 1'b0;
      r_data_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (r_state == ARB_IDLE && w_any) r_owner <= w_win;
      if (w_done) r_rr_last <= w_sel;
      r_addr_done <= !w_done && (r_addr_done || w_addr_hs);
      r_data_done <= !w_done && (r_data_done || w_data_hs);
      if (mem_resp_valid && w_empty) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      (r_state == ARB_IDLE): if (w_any && !w_done) w_state_nxt = ARB_LOCK;
      (r_state == ARB_LOCK): if (w_done) w_state_nxt = ARB_IDLE;
      default:               w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_s_valid  = ic_req_valid;
    w_s_rw     = ic_req_rw;
    w_s_addr   = ic_req_addr;
    w_s_dvalid = ic_data_valid;
    w_s_bits   = ic_data_bits;
    w_s_mask   = ic_data_mask;
    if (w_sel == REQ_DC) begin
      w_s_valid  = dc_req_valid;
      w_s_rw     = dc_req_rw;
      w_s_addr   = dc_req_addr;
      w_s_dvalid = dc_data_valid;
      w_s_bits   = dc_data_bits;
      w_s_mask   = dc_data_mask;
    end
  end

  // A side already handshaked is masked so it is never presented twice.
  assign mem_req_valid      = w_act && w_s_valid && !r_addr_done;
  assign mem_req_rw         = w_s_rw;
  assign mem_req_addr       = w_s_addr;
  assign mem_req_data_valid = w_act && w_s_rw && w_s_dvalid && !r_data_done;
  assign mem_req_data_bits  = w_s_bits;
  assign mem_req_data_mask  = w_s_mask;

  assign w_addr_hs = mem_req_valid && mem_req_ready;
  assign w_data_hs = mem_req_data_valid && mem_req_data_ready;
  assign w_done    = w_act && (w_s_rw ?
                     ((r_addr_done || w_addr_hs) && (r_data_done || w_data_hs)) :
                     w_addr_hs);
  assign w_push    = w_addr_hs && !w_s_rw;

  assign ic_req_ready  = w_addr_hs && (w_sel == REQ_IC);
  assign dc_req_ready  = w_addr_hs && (w_sel == REQ_DC);
  assign ic_data_ready = w_data_hs && (w_sel == REQ_IC);
  assign dc_data_ready = w_data_hs && (w_sel == REQ_DC);

  assign ic_resp_valid   = mem_resp_valid && !w_empty && (w_head == REQ_IC);
  assign dc_resp_valid   = mem_resp_valid && !w_empty && (w_head == REQ_DC);
  assign ic_resp_data    = mem_resp_data;
  assign dc_resp_data    = mem_resp_data;
  assign err_orphan_resp = r_err;

  mem_arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_push_id (w_sel),
    .i_pop     (mem_resp_valid),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_empty   (w_empty)
  );

endmodule
